// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types, mode encodings and one-hot helper for the
//               binary-to-one-hot decoder / scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // Widest select supported; onehot() is sized for this and callers
    // truncate to their own output width.
    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : dwell_counter
// Description : Loadable down-counter. While enabled it counts down to zero,
//               flags terminal count for that cycle and reloads itself.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic               enable,
    input  logic [DWELL_W-1:0] load_val,
    output logic               tc
);

    logic [DWELL_W-1:0] r_count;

    // Clear has priority over load; an enabled count at zero reloads so the
    // reload value is sampled exactly when the next hold period starts.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (enable) begin
            if (r_count == '0) begin
                r_count <= load_val;
            end else begin
                r_count <= r_count - DWELL_W'(1);
            end
        end
    end

    assign tc = enable && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/decoder_scan_nto2n.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_nto2n
// Description : Registered binary-to-one-hot decoder. DECODE mode decodes a
//               handshaked select word with one cycle of latency; SCAN mode
//               walks a single active line with a programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_nto2n
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  step,
    output logic                  wrap
);

    localparam int c_OUT_W = 2**SEL_W;

    state_t               r_state;
    state_t               w_next;
    logic [c_OUT_W-1:0]   r_hot;
    logic                 r_out_valid;
    logic [SEL_W-1:0]     r_cur_sel;
    logic                 r_step;
    logic                 r_wrap;

    logic [c_OUT_W-1:0]   w_sel_hot;
    logic [c_OUT_W-1:0]   w_idx_hot;
    logic [SEL_W-1:0]     w_idx_next;
    logic                 w_accept;
    logic                 w_consume;
    logic                 w_tc;
    logic                 w_scan_entry;
    logic                 w_scan_run;

    // Ready only while decoding with no mode change pending; a requested
    // switch to SCAN blocks new words so the pending one can drain.
    assign in_ready  = en && (r_state == DECODE) && (mode == MODE_DECODE)
                       && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    assign w_idx_next = r_cur_sel + SEL_W'(1);
    assign w_sel_hot  = c_OUT_W'(onehot(MAX_SEL_W'(in_sel)));
    assign w_idx_hot  = c_OUT_W'(onehot(MAX_SEL_W'(w_idx_next)));

    assign w_scan_entry = (w_next == SCAN) && (r_state != SCAN);
    assign w_scan_run   = (w_next == SCAN) && (r_state == SCAN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every mode change is routed through IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_next = (mode == MODE_SCAN) ? SCAN : DECODE;
                end
            end
            DECODE: begin
                if ((mode != MODE_DECODE) && (!r_out_valid || out_ready)) begin
                    w_next = IDLE;
                end
            end
            SCAN: begin
                if (mode != MODE_SCAN) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (!en) begin
            w_next = IDLE;
        end
    end

    // Output registers, updated according to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hot       <= '0;
            r_out_valid <= 1'b0;
            r_cur_sel   <= '0;
            r_step      <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            unique case (w_next)
                SCAN: begin
                    r_out_valid <= 1'b0;
                    if (w_scan_entry) begin
                        r_hot     <= c_OUT_W'(1);
                        r_cur_sel <= '0;
                        r_step    <= 1'b1;
                        r_wrap    <= 1'b1;
                    end else if (w_tc) begin
                        r_hot     <= w_idx_hot;
                        r_cur_sel <= w_idx_next;
                        r_step    <= 1'b1;
                        r_wrap    <= (w_idx_next == '0);
                    end else begin
                        r_step    <= 1'b0;
                        r_wrap    <= 1'b0;
                    end
                end
                DECODE: begin
                    r_step <= 1'b0;
                    r_wrap <= 1'b0;
                    if (w_accept) begin
                        r_hot       <= w_sel_hot;
                        r_cur_sel   <= in_sel;
                        r_out_valid <= 1'b1;
                    end else if (w_consume) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_hot       <= '0;
                    r_out_valid <= 1'b0;
                    r_cur_sel   <= '0;
                    r_step      <= 1'b0;
                    r_wrap      <= 1'b0;
                end
            endcase
        end
    end

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (!(w_next == SCAN)),
        .load     (w_scan_entry),
        .enable   (w_scan_run),
        .load_val (dwell),
        .tc       (w_tc)
    );

    // Polarity is applied only at the port boundary.
    generate
        if (ACTIVE_LOW) begin : g_active_low
            assign out = ~r_hot;
        end else begin : g_active_high
            assign out = r_hot;
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign cur_sel   = r_cur_sel;
    assign step      = r_step;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_nto2n.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan_nto2n
// Description : Self-checking bench for decoder_scan_nto2n. Two instances
//               (active-high and active-low) share stimulus and are compared
//               against a behavioural model of the decode/scan rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_nto2n;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;
    localparam int N       = 4;

    logic               clk;
    logic               rst;
    logic               en;
    logic               mode;
    logic               in_valid;
    logic [SEL_W-1:0]   in_sel;
    logic [DWELL_W-1:0] dwell;
    logic               out_ready;

    logic               in_ready,  in_ready_al;
    logic [N-1:0]       out,       out_al;
    logic               out_valid, out_valid_al;
    logic [SEL_W-1:0]   cur_sel,   cur_sel_al;
    logic               step,      step_al;
    logic               wrap,      wrap_al;

    logic [9:0]         got_v, got_al;

    int n_checks;
    int n_fail;

    // Behavioural model: phase 0 = idle, 1 = decoding, 2 = scanning.
    int           m_phase;
    logic [N-1:0] m_out;
    logic         m_have;
    logic [1:0]   m_sel;
    logic         m_step, m_wrap;
    int           m_line, m_age, m_len;

    decoder_scan_nto2n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_sel(in_sel), .dwell(dwell), .out(out),
        .out_valid(out_valid), .out_ready(out_ready), .cur_sel(cur_sel),
        .step(step), .wrap(wrap)
    );

    decoder_scan_nto2n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready_al), .in_sel(in_sel), .dwell(dwell), .out(out_al),
        .out_valid(out_valid_al), .out_ready(out_ready), .cur_sel(cur_sel_al),
        .step(step_al), .wrap(wrap_al)
    );

    assign got_v  = {in_ready, out_valid, cur_sel, step, wrap, out};
    assign got_al = {in_ready_al, out_valid_al, cur_sel_al, step_al, wrap_al, out_al};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_ready();
        return en && (m_phase == 1) && !mode && (!m_have || out_ready);
    endfunction

    function automatic logic [9:0] m_vec(input logic al);
        return {m_ready(), m_have, m_sel, m_step, m_wrap, (al ? ~m_out : m_out)};
    endfunction

    // Advance one clock and update the model from the pre-edge inputs.
    task automatic tick();
        logic acc, cons, s_rst;
        logic [1:0] s_sel;
        int nxt, s_dwell;
        acc     = m_ready() && in_valid;
        cons    = m_have && out_ready;
        s_rst   = rst;
        s_sel   = in_sel;
        s_dwell = int'(dwell);
        if (!en)               nxt = 0;
        else if (m_phase == 0) nxt = mode ? 2 : 1;
        else if (m_phase == 1) nxt = (mode && (!m_have || out_ready)) ? 0 : 1;
        else                   nxt = mode ? 2 : 0;
        @(posedge clk);
        if (s_rst || nxt == 0) begin
            m_out = '0; m_have = 0; m_sel = '0; m_step = 0; m_wrap = 0;
            nxt = 0;
        end else if (nxt == 2) begin
            if (m_phase != 2) begin
                m_line = 0; m_age = 0; m_len = s_dwell + 1;
                m_step = 1; m_wrap = 1;
            end else begin
                m_age++;
                if (m_age == m_len) begin
                    m_line = (m_line + 1) % N; m_age = 0; m_len = s_dwell + 1;
                    m_step = 1; m_wrap = (m_line == 0);
                end else begin
                    m_step = 0; m_wrap = 0;
                end
            end
            m_out = N'(1 << m_line); m_sel = 2'(m_line); m_have = 0;
        end else begin
            m_step = 0; m_wrap = 0;
            if (acc) begin
                m_out = N'(1 << s_sel); m_sel = s_sel; m_have = 1;
            end else if (cons) begin
                m_have = 0;
            end
        end
        m_phase = nxt;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mode = 1; in_valid = 0; out_ready = 0; in_sel = '0; dwell = '0;
        tick(); tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) rst = 0;
            #1;
            if (c < 2) begin
                n_checks++;
                if ({out, out_valid, step, wrap} !== 7'b0) begin
                    n_fail++; $display("FAIL reset_vals c=%0d got %b exp 0000000", c, {out, out_valid, step, wrap});
                end
            end
            n_checks++;
            if (got_v !== m_vec(0)) begin
                n_fail++; $display("FAIL reset_model c=%0d got %b exp %b", c, got_v, m_vec(0));
            end
            n_checks++;
            if (got_al !== m_vec(1)) begin
                n_fail++; $display("FAIL reset_al c=%0d got %b exp %b", c, got_al, m_vec(1));
            end
            tick();
        end
    endtask

    task automatic test_decode_stream();
        logic [1:0] seq [3] = '{2'd3, 2'd0, 2'd2};
        logic [3:0] exp [3] = '{4'b1000, 4'b0001, 4'b0100};
        rst = 1; en = 1; mode = 0; out_ready = 1; in_valid = 0;
        tick(); rst = 0; tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 3);
            in_sel   = (i < 3) ? seq[i] : 2'd0;
            #1;
            n_checks++;
            if (got_v !== m_vec(0)) begin
                n_fail++; $display("FAIL stream_model i=%0d got %b exp %b", i, got_v, m_vec(0));
            end
            n_checks++;
            if (got_al !== m_vec(1)) begin
                n_fail++; $display("FAIL stream_al i=%0d got %b exp %b", i, got_al, m_vec(1));
            end
            tick();
            if (i < 3) begin
                n_checks++;
                if ({out, out_valid, cur_sel} !== {exp[i], 1'b1, seq[i]}) begin
                    n_fail++; $display("FAIL stream_out i=%0d got %b exp %b", i, {out, out_valid, cur_sel}, {exp[i], 1'b1, seq[i]});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0; in_valid = 1; in_sel = 2'd1;
        #1;
        n_checks++;
        if (got_v !== m_vec(0)) begin
            n_fail++; $display("FAIL bp_model got %b exp %b", got_v, m_vec(0));
        end
        tick();
        in_sel = 2'd3;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({in_ready, out, out_valid} !== {1'b0, 4'b0010, 1'b1}) begin
                n_fail++; $display("FAIL bp_hold c=%0d got %b exp 0_0010_1", c, {in_ready, out, out_valid});
            end
            n_checks++;
            if (got_v !== m_vec(0)) begin
                n_fail++; $display("FAIL bp_model c=%0d got %b exp %b", c, got_v, m_vec(0));
            end
            tick();
        end
        out_ready = 1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got %b exp 1", in_ready);
        end
        tick();
        n_checks++;
        if ({out, cur_sel, out_valid} !== {4'b1000, 2'd3, 1'b1}) begin
            n_fail++; $display("FAIL bp_next got %b exp 1000_11_1", {out, cur_sel, out_valid});
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_scan();
        rst = 1; en = 1; mode = 1; dwell = 8'd2; in_valid = 1; out_ready = 0;
        tick(); rst = 0;
        for (int c = 0; c < 25; c++) begin
            in_sel = 2'($urandom_range(0, 3));
            tick();
            n_checks++;
            if ({out, step, wrap} !== {4'(1 << ((c / 3) % 4)), (c % 3 == 0), (c % 12 == 0)}) begin
                n_fail++; $display("FAIL scan_seq c=%0d got %b exp %b", c, {out, step, wrap},
                                   {4'(1 << ((c / 3) % 4)), (c % 3 == 0), (c % 12 == 0)});
            end
            n_checks++;
            if (got_v !== m_vec(0)) begin
                n_fail++; $display("FAIL scan_model c=%0d got %b exp %b", c, got_v, m_vec(0));
            end
        end
        in_valid = 0;
    endtask

    task automatic test_scan_active_low();
        logic [3:0] exp_al [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst = 1; en = 1; mode = 1; dwell = 8'd0;
        tick(); rst = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({out_al, step_al} !== {exp_al[k], 1'b1}) begin
                n_fail++; $display("FAIL scan_al k=%0d got %b exp %b", k, {out_al, step_al}, {exp_al[k], 1'b1});
            end
            n_checks++;
            if (got_al !== m_vec(1)) begin
                n_fail++; $display("FAIL scan_al_model k=%0d got %b exp %b", k, got_al, m_vec(1));
            end
        end
        en = 0;
        tick();
        n_checks++;
        if ({out_al, out} !== 8'b1111_0000) begin
            n_fail++; $display("FAIL scan_al_off got %b exp 11110000", {out_al, out});
        end
    endtask

    task automatic test_mode_switch();
        rst = 1; en = 1; mode = 0; out_ready = 0; in_valid = 0; dwell = 8'd1;
        tick(); rst = 0; tick();
        in_valid = 1; in_sel = 2'd2;
        tick();
        in_valid = 1; mode = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({in_ready, out, out_valid} !== {1'b0, 4'b0100, 1'b1}) begin
                n_fail++; $display("FAIL switch_hold c=%0d got %b exp 0_0100_1", c, {in_ready, out, out_valid});
            end
            tick();
        end
        out_ready = 1;
        tick();
        n_checks++;
        if ({out, out_valid, step} !== 6'b0000_0_0) begin
            n_fail++; $display("FAIL switch_idle got %b exp 000000", {out, out_valid, step});
        end
        n_checks++;
        if (got_v !== m_vec(0)) begin
            n_fail++; $display("FAIL switch_model got %b exp %b", got_v, m_vec(0));
        end
        tick();
        n_checks++;
        if ({out, step, wrap} !== 6'b0001_1_1) begin
            n_fail++; $display("FAIL switch_scan got %b exp 000111", {out, step, wrap});
        end
        in_valid = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) < 2);
            en        = ($urandom_range(0, 99) < 95);
            if ($urandom_range(0, 99) < 6) mode = ~mode;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            in_sel    = 2'($urandom_range(0, 3));
            dwell     = 8'($urandom_range(0, 3));
            #1;
            n_checks++;
            if (got_v !== m_vec(0)) begin
                n_fail++; $display("FAIL random c=%0d got %b exp %b", c, got_v, m_vec(0));
            end
            n_checks++;
            if (got_al !== m_vec(1)) begin
                n_fail++; $display("FAIL random_al c=%0d got %b exp %b", c, got_al, m_vec(1));
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_phase = 0; m_out = '0; m_have = 0; m_sel = '0; m_step = 0; m_wrap = 0;
        m_line = 0; m_age = 0; m_len = 1;
        rst = 1; en = 0; mode = 0; in_valid = 0; out_ready = 0; in_sel = '0; dwell = '0;
        test_reset();
        test_decode_stream();
        test_backpressure();
        test_scan();
        test_scan_active_low();
        test_mode_switch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
